segre_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the Segre in-order core. Sits beside the IF/ID/EX/MEM stages and drives their block and NOP-injection controls. It resolves three hazard classes: load-use RAW stalls, taken-branch/jump flushes signalled by EX, and multi-cycle data-memory waits. It is a small FSM with a shared down-counter, replacing ad-hoc per-stage stall glue.

---
 rtl/segre_pkg.sv | 14 +
 rtl/segre_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_segre_hazard_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/segre_pkg.sv
// Shared types for the Segre core pipeline control.
// Hazard FSM state encoding and register-address width.
package segre_pkg;

  localparam int unsigned REG_SIZE = 5;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_LOAD  = 2'd1,
    HZ_FLUSH = 2'd2,
    HZ_MEMW  = 2'd3
  } hz_state_e;

endpackage

// File: rtl/segre_hazard_ctrl.sv
// Segre hazard controller: load-use stalls, branch flushes, dmem waits.
// Optional perf counters with `define SEGRE_HAZARD_PERF_EN.
module segre_hazard_ctrl
  import segre_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 2
) (
  input  logic                clk_i,
  input  logic                rsn_i,
  input  logic [REG_SIZE-1:0] id_rs1_addr_i,
  input  logic [REG_SIZE-1:0] id_rs2_addr_i,
  input  logic                id_uses_rs1_i,
  input  logic                id_uses_rs2_i,
  input  logic                ex_memop_rd_i,
  input  logic                ex_rf_we_i,
  input  logic [REG_SIZE-1:0] ex_rf_waddr_i,
  input  logic                tkbr_i,
  input  logic                mem_busy_i,
  output logic                block_if_o,
  output logic                block_id_o,
  output logic                block_ex_o,
  output logic                block_mem_o,
  output logic                kill_id_o,
  output logic                inject_nops_ex_o,
  output logic                inject_nops_wb_o,
  output logic [1:0]          hz_state_o
`ifdef SEGRE_HAZARD_PERF_EN
  ,
  output logic [31:0]         perf_stall_cnt_o,
  output logic [31:0]         perf_flush_cnt_o
`endif
);

  localparam logic [2:0] LOAD_INIT  = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  hz_state_e  state_q, state_d;
  hz_state_e  ret_q, ret_d;
  hz_state_e  cur;
  logic [2:0] cnt_q, cnt_d;
  logic       load_use;
  logic       flush_entry;
  logic       b_if, b_id, b_ex, b_mem;
  logic       kill, nop_ex, nop_wb;

  assign load_use = ex_memop_rd_i & ex_rf_we_i &
                    (ex_rf_waddr_i != '0) &
                    ((id_uses_rs1_i &
                      (id_rs1_addr_i == ex_rf_waddr_i)) |
                     (id_uses_rs2_i &
                      (id_rs2_addr_i == ex_rf_waddr_i)));

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    cnt_d       = cnt_q;
    flush_entry = 1'b0;
    b_if        = 1'b0;
    b_id        = 1'b0;
    b_ex        = 1'b0;
    b_mem       = 1'b0;
    kill        = 1'b0;
    nop_ex      = 1'b0;
    nop_wb      = 1'b0;
    // On leaving MEMW the saved state acts in the same cycle.
    cur = (state_q == HZ_MEMW) ? ret_q : state_q;
    if (mem_busy_i) begin
      b_if    = 1'b1;
      b_id    = 1'b1;
      b_ex    = 1'b1;
      b_mem   = 1'b1;
      nop_wb  = 1'b1;
      ret_d   = cur;
      state_d = HZ_MEMW;
    end else begin
      unique case (cur)
        HZ_RUN: begin
          state_d = HZ_RUN;
          if (tkbr_i) begin
            kill        = 1'b1;
            nop_ex      = 1'b1;
            flush_entry = 1'b1;
            cnt_d       = FLUSH_INIT;
            if (FLUSH_INIT != 3'd0) state_d = HZ_FLUSH;
          end else if (load_use) begin
            b_if   = 1'b1;
            b_id   = 1'b1;
            nop_ex = 1'b1;
            cnt_d  = LOAD_INIT;
            if (LOAD_INIT != 3'd0) state_d = HZ_LOAD;
          end
        end
        HZ_LOAD: begin
          b_if    = 1'b1;
          b_id    = 1'b1;
          nop_ex  = 1'b1;
          cnt_d   = cnt_q - 3'd1;
          state_d = (cnt_d == 3'd0) ? HZ_RUN : HZ_LOAD;
        end
        HZ_FLUSH: begin
          kill    = 1'b1;
          nop_ex  = 1'b1;
          cnt_d   = cnt_q - 3'd1;
          state_d = (cnt_d == 3'd0) ? HZ_RUN : HZ_FLUSH;
        end
        default: state_d = HZ_RUN;
      endcase
    end
  end

  assign block_if_o       = rsn_i & b_if;
  assign block_id_o       = rsn_i & b_id;
  assign block_ex_o       = rsn_i & b_ex;
  assign block_mem_o      = rsn_i & b_mem;
  assign kill_id_o        = rsn_i & kill;
  assign inject_nops_ex_o = rsn_i & nop_ex;
  assign inject_nops_wb_o = rsn_i & nop_wb;
  assign hz_state_o       = rsn_i ? state_q : 2'b00;

`ifdef SEGRE_HAZARD_PERF_EN
  logic [31:0] stall_q, flush_q;
  assign perf_stall_cnt_o = stall_q;
  assign perf_flush_cnt_o = flush_q;
`endif

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state_q <= HZ_RUN;
      ret_q   <= HZ_RUN;
      cnt_q   <= 3'd0;
`ifdef SEGRE_HAZARD_PERF_EN
      stall_q <= 32'd0;
      flush_q <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
`ifdef SEGRE_HAZARD_PERF_EN
      if (b_id)        stall_q <= stall_q + 32'd1;
      if (flush_entry) flush_q <= flush_q + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_segre_hazard_ctrl.sv
// Randomized bench for segre_hazard_ctrl against an episode-level model.
// Perf counter checks compile in with `define SEGRE_HAZARD_PERF_EN.
module tb_segre_hazard_ctrl;
  import segre_pkg::*;

  localparam int LSC = 3;
  localparam int FC  = 2;

  logic       clk = 1'b0;
  logic       rsn;
  logic [4:0] rs1, rs2, wa;
  logic       u1, u2, ld, we, tk, bz;
  logic       b_if, b_id, b_ex, b_mem, kill, nex, nwb;
  logic [1:0] st;
`ifdef SEGRE_HAZARD_PERF_EN
  logic [31:0] p_stall, p_flush;
`endif

  always #5 clk = ~clk;

  segre_hazard_ctrl #(
    .LOAD_STALL_CYCLES(LSC),
    .FLUSH_CYCLES     (FC)
  ) dut (
    .clk_i           (clk),
    .rsn_i           (rsn),
    .id_rs1_addr_i   (rs1),
    .id_rs2_addr_i   (rs2),
    .id_uses_rs1_i   (u1),
    .id_uses_rs2_i   (u2),
    .ex_memop_rd_i   (ld),
    .ex_rf_we_i      (we),
    .ex_rf_waddr_i   (wa),
    .tkbr_i          (tk),
    .mem_busy_i      (bz),
    .block_if_o      (b_if),
    .block_id_o      (b_id),
    .block_ex_o      (b_ex),
    .block_mem_o     (b_mem),
    .kill_id_o       (kill),
    .inject_nops_ex_o(nex),
    .inject_nops_wb_o(nwb),
    .hz_state_o      (st)
`ifdef SEGRE_HAZARD_PERF_EN
    ,
    .perf_stall_cnt_o(p_stall),
    .perf_flush_cnt_o(p_flush)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model: remaining cycles of the open episode and its kind
  // (1 load stall, 2 flush); m_memw says last cycle waited on dmem.
  int          m_rem  = 0;
  int          m_kind = 0;
  bit          m_memw = 1'b0;
  logic [31:0] m_stall = 0;
  logic [31:0] m_flush = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit r, input logic [4:0] a1,
                      input logic [4:0] a2, input bit x1, input bit x2,
                      input bit l, input bit w, input logic [4:0] d,
                      input bit t, input bit b);
    bit lu, e_if, e_id, e_ex, e_mem, e_kill, e_nex, e_nwb;
    int e_st;
    @(negedge clk);
    rsn = r; rs1 = a1; rs2 = a2; u1 = x1; u2 = x2;
    ld = l; we = w; wa = d; tk = t; bz = b;
    #1;
`ifdef SEGRE_HAZARD_PERF_EN
    chk("perf_stall", p_stall, m_stall);
    chk("perf_flush", p_flush, m_flush);
`endif
    lu = l && w && d != 0 &&
         ((x1 && a1 == d) || (x2 && a2 == d));
    {e_if, e_id, e_ex, e_mem, e_kill, e_nex, e_nwb} = '0;
    e_st = !r ? 0 : m_memw ? 3 : (m_rem > 0 ? m_kind : 0);
    if (!r) begin
    end else if (b) begin
      {e_if, e_id, e_ex, e_mem, e_nwb} = '1;
    end else if (m_rem > 0) begin
      if (m_kind == 2) {e_kill, e_nex} = '1;
      else {e_if, e_id, e_nex} = '1;
      m_rem--;
    end else if (t) begin
      {e_kill, e_nex} = '1;
      m_rem  = FC - 1;
      m_kind = 2;
      m_flush++;
    end else if (lu) begin
      {e_if, e_id, e_nex} = '1;
      m_rem  = LSC - 1;
      m_kind = 1;
    end
    chk("block_if", 32'(b_if), 32'(e_if));
    chk("block_id", 32'(b_id), 32'(e_id));
    chk("block_ex", 32'(b_ex), 32'(e_ex));
    chk("block_mem", 32'(b_mem), 32'(e_mem));
    chk("kill_id", 32'(kill), 32'(e_kill));
    chk("nops_ex", 32'(nex), 32'(e_nex));
    chk("nops_wb", 32'(nwb), 32'(e_nwb));
    chk("hz_state", 32'(st), 32'(e_st));
    if (!r) begin
      m_rem = 0; m_kind = 0; m_memw = 1'b0;
      m_stall = 0; m_flush = 0;
    end else begin
      m_memw = b;
      if (e_id) m_stall++;
    end
  endtask

  task automatic idle(input int n, input bit b);
    for (int i = 0; i < n; i++)
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, b);
  endtask

  initial begin
    rsn = 1'b0; rs1 = '0; rs2 = '0; wa = '0;
    {u1, u2, ld, we, tk, bz} = '0;
    // Reset with hazards on the inputs must still give zeros.
    step(0, 5, 1, 1, 1, 1, 1, 5, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Load x5, ID add x6,x5,x1.
    step(1, 5, 1, 1, 1, 1, 1, 5, 0, 0);
    idle(LSC + 1, 0);
    // Same with destination x0.
    step(1, 0, 1, 1, 1, 1, 1, 0, 0, 0);
    idle(1, 0);
    // Taken branch.
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(FC + 1, 0);
    // Branch together with a load-use match.
    step(1, 7, 2, 1, 1, 1, 1, 7, 1, 0);
    idle(FC + 1, 0);
    // Flush interrupted by a 3-cycle memory wait.
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3, 1);
    idle(FC + 1, 0);
    // Memory wait with branch pending in EX.
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(FC + 1, 0);
    // Reset in the middle of a load stall.
    step(1, 3, 3, 0, 1, 1, 1, 3, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2, 0);
    // Random traffic on a small register window.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(99) >= 2,
           5'($urandom_range(3)), 5'($urandom_range(3)),
           1'($urandom), 1'($urandom),
           $urandom_range(99) < 50, $urandom_range(99) < 80,
           5'($urandom_range(3)),
           $urandom_range(99) < 12, $urandom_range(99) < 20);
    end
    idle(10, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
